// File: rtl/bch_pkg.sv
// Shared BCH decode-path definitions: code identifiers, IBM solve latencies
// and the frame sequencer state encoding.
package bch_pkg;

    localparam logic [1:0] CODE_LONG = 2'b10;
    localparam int         LAT_LONG  = 8;
    localparam int         LAT_SHORT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ibm_frame_ctrl_rbuf.sv
// One-deep result slot between the IBM solver and the Chien stage: holds the
// full flag, the frame tag and the no-error flag of the buffered sigma.
module ibm_frame_ctrl_rbuf #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_zero,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_full;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag;

    // A load wins over a drain so a simultaneous drain+load leaves the slot full.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_zero <= 1'b0;
            r_tag  <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_zero <= i_zero;
            r_tag  <= i_tag;
        end else if (i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_valid = r_full;
    assign o_zero  = r_zero;
    assign o_tag   = r_tag;

endmodule

// File: rtl/ibm_frame_ctrl.sv
// Frame sequencer for the IBM key-equation solver. Optional macro
// IBM_FRAME_CTRL_SKIP_ZERO_EN writes all-zero-syndrome frames straight to the result buffer.
module ibm_frame_ctrl
    import bch_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TAG_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_code,
    input  logic             i_mode,
    input  logic             i_syn_valid,
    output logic             o_syn_ready,
    input  logic             i_syn_zero,
    output logic             o_ibm_clear_and_wen,
    output logic [1:0]       o_ibm_code,
    output logic             o_ibm_mode,
    input  logic             i_ibm_valid,
    output logic             o_sig_load,
    output logic             o_sig_valid,
    input  logic             i_sig_ready,
    output logic             o_sig_zero,
    output logic [TAG_W-1:0] o_sig_tag,
    output logic             o_err,
    output logic             o_busy
);

    // A timeout shorter than the long-code latency would abort every healthy solve.
    localparam int               TIMEOUT_EFF = (TIMEOUT > LAT_LONG) ? TIMEOUT : LAT_LONG + 1;
    localparam int               LAT_W       = $clog2(TIMEOUT_EFF + 1);
    localparam logic [LAT_W-1:0] LAT_MAX     = LAT_W'(TIMEOUT_EFF);

    state_t           r_state;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [1:0]       r_code;
    logic             r_mode;
    logic [TAG_W-1:0] r_tag_cnt;

    logic w_idle;
    logic w_solving;
    logic w_buf_free;
    logic w_accept;
    logic w_zero_frame;
    logic w_ibm_accept;
    logic w_ibm_done;
    logic w_timeout;
    logic w_buf_load;

    assign w_idle     = (r_state == IDLE);
    assign w_solving  = (r_state == RUN) || (r_state == HOLD);
    assign w_buf_free = ~o_sig_valid | i_sig_ready;

`ifdef IBM_FRAME_CTRL_SKIP_ZERO_EN
    assign w_zero_frame = i_syn_zero;
    assign o_syn_ready  = i_rst_n & w_idle & (~i_syn_zero | w_buf_free);
`else
    logic w_unused_syn_zero;
    assign w_unused_syn_zero = i_syn_zero;
    assign w_zero_frame      = 1'b0;
    assign o_syn_ready       = i_rst_n & w_idle;
`endif

    // NOTE: the clear pulse is combinational so it lands in the handshake cycle, while upstream syndromes are live.
    assign w_accept            = i_syn_valid & o_syn_ready;
    assign w_ibm_accept        = w_accept & ~w_zero_frame;
    assign o_ibm_clear_and_wen = w_ibm_accept;

    assign o_ibm_code = w_idle ? (i_code & {2{i_rst_n}}) : r_code;
    assign o_ibm_mode = w_idle ? (i_mode & i_rst_n) : r_mode;

    // i_ibm_valid only counts once the solve has left IDLE; in the accept cycle it is stale.
    assign w_ibm_done = w_solving & i_ibm_valid & w_buf_free;
    assign w_timeout  = (r_state == RUN) & ~i_ibm_valid & (r_lat_cnt == LAT_MAX);
    assign w_buf_load = w_ibm_done | (w_accept & w_zero_frame);

    assign o_sig_load = w_ibm_done;
    assign o_err      = w_timeout;
    assign o_busy     = ~w_idle;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_code    <= 2'b00;
            r_mode    <= 1'b0;
            r_tag_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ibm_accept) begin
                        r_state   <= RUN;
                        r_lat_cnt <= LAT_W'(1);
                        r_code    <= i_code;
                        r_mode    <= i_mode;
                    end
                end
                RUN: begin
                    if (w_ibm_done)       r_state <= IDLE;
                    else if (i_ibm_valid) r_state <= HOLD;
                    else if (w_timeout)   r_state <= IDLE;
                    else                  r_lat_cnt <= r_lat_cnt + 1'b1;
                end
                HOLD: begin
                    if (w_ibm_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_buf_load) r_tag_cnt <= r_tag_cnt + 1'b1;
        end
    end

    ibm_frame_ctrl_rbuf #(
        .TAG_W (TAG_W)
    ) u_rbuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_buf_load),
        .i_zero  (w_idle),
        .i_tag   (r_tag_cnt),
        .i_ready (i_sig_ready),
        .o_valid (o_sig_valid),
        .o_zero  (o_sig_zero),
        .o_tag   (o_sig_tag)
    );

endmodule
